// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction core over a DW-bit register file.
// External instruction/data memories via req/ready handshakes.
module multicycle_cpu #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ready,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic          halted,
  output logic [AW-1:0] pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state, state_nxt;

  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] a, b, d, res;
  logic [AW-1:0] addr;
  logic          fetching;
  logic [DW-1:0] regs [NREG];

  logic [3:0]    op;
  logic [2:0]    rd, rs, rt;
  logic [DW-1:0] imm_dw;
  logic [AW-1:0] imm_aw;
  logic [AW-1:0] a_aw;
  logic [DW-1:0] alu_out;
  logic          is_alu, is_mem, is_halt;

  assign op     = ir[15:12];
  assign rd     = ir[11:9];
  assign rs     = ir[8:6];
  assign rt     = ir[5:3];
  assign imm_dw = DW'($signed(ir[5:0]));
  assign imm_aw = AW'($signed(ir[5:0]));

  generate
    if (AW <= DW) begin : g_narrow
      assign a_aw = a[AW-1:0];
    end else begin : g_wide
      assign a_aw = {{(AW-DW){1'b0}}, a};
    end
  endgenerate

  assign is_alu  = (op >= OP_ADD) && (op <= OP_ADDI);
  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_halt = (op == OP_HALT);

  always_comb begin
    unique case (op)
      OP_SUB:  alu_out = a - b;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_ADDI: alu_out = a + imm_dw;
      default: alu_out = a + b;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:  if (imem_req && imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_alu:  state_nxt = S_WB;
          is_mem:  state_nxt = S_MEM;
          is_halt: state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: if (dmem_ready)
        state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // A started fetch stays requested even if enable drops.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_FETCH: imem_req = reset && (enable || fetching);
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_addr  = addr;
  assign dmem_wdata = d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      d        <= '0;
      res      <= '0;
      addr     <= '0;
      fetching <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      fetching <= (state == S_FETCH) && imem_req && !imem_ready;
      unique case (state)
        S_FETCH: if (imem_req && imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + AW'(1);
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          d <= regs[rd];
        end
        S_EXEC: begin
          if (is_alu) res <= alu_out;
          if (is_mem) addr <= a_aw + imm_aw;
          if (op == OP_BEQ && d == a) pc <= pc + imm_aw;
          if (op == OP_JMP) pc <= a_aw;
        end
        S_MEM: if (dmem_ready && op == OP_LW) res <= dmem_rdata;
        S_WB: if (rd != 3'd0) regs[rd] <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: behavioural imem/dmem,
// fetch/store logging, immediate-assertion checks.
module tb_multicycle_cpu;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_ready = 1'b1;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ready = 1'b0;
  logic          halted;
  logic [AW-1:0] pc_out;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dwait = 0;
  int reqlen = 0;
  int fa[$];
  int fc[$];
  int sa[$];
  int sd[$];
  int sl[$];

  multicycle_cpu #(.DW(DW), .AW(AW), .NREG(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .halted(halted), .pc_out(pc_out)
  );

  assign imem_rdata = imem[imem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_req && imem_ready) begin
      fa.push_back(int'(imem_addr));
      fc.push_back(cyc);
    end
  end

  // Data memory answers after dwait idle cycles of a held request.
  always @(negedge clk) begin
    if (!dmem_req) begin
      reqlen = 0;
      dmem_ready = 1'b0;
    end else begin
      dmem_ready = (reqlen == dwait);
      reqlen++;
      if (dmem_ready) begin
        dmem_rdata = dmem[dmem_addr];
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          sa.push_back(int'(dmem_addr));
          sd.push_back(int'(dmem_wdata));
          sl.push_back(reqlen);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input int n, input int budget,
                            input string tag);
    int k = 0;
    while (fa.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(fa.size() >= n), 1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 8'h00;
    end
    fa.delete();
    fc.delete();
    sa.delete();
    sd.delete();
    sl.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int exp_a[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                    14, 15, 20, 21, 22, 23, 24};
  int exp_sa[6] = '{20, 21, 10, 22, 23, 24};
  int exp_sd[6] = '{8'h02, 8'hF8, 8'h05, 8'h05, 8'h00, 8'h14};
  int exp_b[7]  = '{0, 1, 2, 3, 3, 3, 3};
  int exp_c[7]  = '{0, 1, 5, 6, 255, 0, 1};

  initial begin
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);

    // Program A: ALU, memory with 2 wait cycles, R0, branch, jump, halt
    imem[0]  = 16'h5205;
    imem[1]  = 16'h543D;
    imem[2]  = 16'h1650;
    imem[3]  = 16'h2888;
    imem[4]  = 16'h7614;
    imem[5]  = 16'h7815;
    imem[6]  = 16'h720A;
    imem[7]  = 16'h6A0A;
    imem[8]  = 16'h7A16;
    imem[9]  = 16'h5007;
    imem[10] = 16'h1C00;
    imem[11] = 16'h7C17;
    imem[12] = 16'h8001;
    imem[14] = 16'h5E14;
    imem[15] = 16'h91C0;
    imem[20] = 16'h7E18;
    imem[21] = 16'h8285;
    imem[22] = 16'h0000;
    imem[23] = 16'hA000;
    imem[24] = 16'hF000;
    dwait = 2;
    release_reset();
    repeat (5) @(negedge clk);
    chk("idle_imem_req", imem_req, 0);
    chk("idle_pc", pc_out, 0);
    chk("idle_no_fetch", fa.size(), 0);

    enable = 1'b1;
    wait_fetch(20, 400, "progA_timeout");
    for (int i = 0; i < 20; i++)
      chk($sformatf("progA_fetch%0d", i), fa[i], exp_a[i]);
    chk("cpi_addi0", fc[1] - fc[0], 4);
    chk("cpi_addi1", fc[2] - fc[1], 4);
    chk("cpi_add", fc[3] - fc[2], 4);
    chk("cpi_sub", fc[4] - fc[3], 4);
    chk("cpi_sw_w2", fc[5] - fc[4], 6);
    chk("cpi_lw_w2", fc[8] - fc[7], 7);
    chk("cpi_beq", fc[13] - fc[12], 3);
    chk("cpi_jmp", fc[15] - fc[14], 3);
    chk("cpi_nop", fc[18] - fc[17], 3);
    repeat (5) @(negedge clk);
    chk("store_count", sa.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("store%0d_addr", i), sa[i], exp_sa[i]);
      chk($sformatf("store%0d_data", i), sd[i], exp_sd[i]);
    end
    chk("sw_req_cycles", sl[2], 3);
    chk("halted_set", halted, 1);
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      @(negedge clk);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("halt_no_req", imem_req, 0);
    chk("halt_no_fetch", fa.size(), 20);
    chk("halt_hold", halted, 1);
    reset = 1'b0;
    #1;
    chk("halt_reset", halted, 0);
    chk("rst_req_enabled", imem_req, 0);

    // Program B: self-loop branch at pc 3
    clear_mem();
    imem[0] = 16'h0000;
    imem[1] = 16'h0000;
    imem[2] = 16'h0000;
    imem[3] = 16'h803F;
    release_reset();
    #1;
    chk("first_req", imem_req, 1);
    wait_fetch(7, 100, "progB_timeout");
    for (int i = 0; i < 7; i++)
      chk($sformatf("progB_fetch%0d", i), fa[i], exp_b[i]);
    chk("cpi_beq_loop", fc[4] - fc[3], 3);
    reset = 1'b0;

    // Program C: jump to 5, jump to 0xFF, pc wraps to 0
    clear_mem();
    imem[0]   = 16'h5205;
    imem[1]   = 16'h9040;
    imem[5]   = 16'h523F;
    imem[6]   = 16'h9040;
    imem[255] = 16'h0000;
    release_reset();
    wait_fetch(7, 100, "progC_timeout");
    for (int i = 0; i < 7; i++)
      chk($sformatf("progC_fetch%0d", i), fa[i], exp_c[i]);
    reset = 1'b0;

    // Program D: reset during a long data access
    clear_mem();
    imem[0] = 16'h7001;
    dwait = 50;
    release_reset();
    for (int k = 0; k < 20 && !dmem_req; k++) @(negedge clk);
    chk("memD_req", dmem_req, 1);
    chk("memD_addr", dmem_addr, 1);
    chk("memD_we", dmem_we, 1);
    reset = 1'b0;
    #1;
    chk("memD_rst_req", dmem_req, 0);
    chk("memD_rst_we", dmem_we, 0);
    chk("memD_rst_addr", dmem_addr, 0);
    enable = 1'b0;
    release_reset();
    repeat (5) @(negedge clk);
    chk("memD_idle_req", imem_req, 0);
    chk("memD_idle_pc", pc_out, 0);
    chk("memD_no_store", sa.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
